// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the two-port adder arbiter: FSM encoding, port
// indices and the tie-break helper.
package adder_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Winner for this IDLE cycle; with FAIR the port that did not win last goes first.
    function automatic logic arb_pick(input logic req0, input logic req1,
                                      input logic last_gnt, input logic fair);
        logic win;
        if (req0 && req1) begin
            if (fair) begin
                win = ~last_gnt;
            end else begin
                win = PORT0;
            end
        end else if (req1) begin
            win = PORT1;
        end else begin
            win = PORT0;
        end
        return win;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_adder_8bits.sv
// Plain 8-bit unsigned adder with carry out; the shared datapath.
module adder_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arbiter.sv
// Two-requester arbiter around one adder_8bits: grant, latch operands, add,
// return a registered 9-bit sum with a one-cycle ack, and count completed ops.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int FAIR  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [7:0]       a0,
    input  logic [7:0]       b0,
    input  logic             req1,
    input  logic [7:0]       a1,
    input  logic [7:0]       b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [8:0]       sum,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic               win_r;
    logic               win_nxt_s;
    logic               last_gnt_r;
    logic               load_s;
    logic [7:0]         a_r;
    logic [7:0]         b_r;
    logic [7:0]         add_s_s;
    logic               add_c_s;
    logic [8:0]         sum_r;
    logic               gnt0_r;
    logic               gnt1_r;
    logic               ack0_r;
    logic               ack1_r;
    logic               busy_r;
    logic [CNT_W-1:0]   op_count_r;

    // Next-state and arbitration decision
    always_comb begin
        state_nxt_s = state_r;
        win_nxt_s   = win_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_nxt_s = ST_ADD;
                    win_nxt_s   = arb_pick(req0, req1, last_gnt_r, FAIR != 0);
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADD:  state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, current winner and tie-break history (port 0 wins the first tie)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            win_r      <= PORT0;
            last_gnt_r <= PORT1;
        end else begin
            state_r <= state_nxt_s;
            win_r   <= win_nxt_s;
            if (state_r == ST_RESP) begin
                last_gnt_r <= win_r;
            end
        end
    end

    // Operand capture; the adder only ever sees these copies, never the live ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= 8'h00;
            b_r <= 8'h00;
        end else if (load_s) begin
            a_r <= (win_nxt_s == PORT1) ? a1 : a0;
            b_r <= (win_nxt_s == PORT1) ? b1 : b0;
        end
    end

    adder_8bits u_adder (
        .a     (a_r),
        .b     (b_r),
        .s     (add_s_s),
        .c_out (add_c_s)
    );

    // Result register, loaded at the end of ADD and held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 9'h000;
        end else if (state_r == ST_ADD) begin
            sum_r <= {add_c_s, add_s_s};
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            gnt0_r <= (state_nxt_s != ST_IDLE) && (win_nxt_s == PORT0);
            gnt1_r <= (state_nxt_s != ST_IDLE) && (win_nxt_s == PORT1);
            ack0_r <= (state_nxt_s == ST_RESP) && (win_nxt_s == PORT0);
            ack1_r <= (state_nxt_s == ST_RESP) && (win_nxt_s == PORT1);
        end
    end

    // Completed-operation counter, wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_RESP) begin
            op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign busy     = busy_r;
    assign sum      = sum_r;
    assign op_count = op_count_r;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: a fair 16-bit-counter instance and a
// fixed-priority 4-bit-counter instance, checked against hand-computed values.
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        gnt0, gnt1, ack0, ack1, busy;
    logic [8:0]  sum;
    logic [15:0] op_count;

    logic        f_req0, f_req1;
    logic [7:0]  f_a0, f_b0, f_a1, f_b1;
    logic        f_gnt0, f_gnt1, f_ack0, f_ack1, f_busy;
    logic [8:0]  f_sum;
    logic [3:0]  f_op_count;

    int errors = 0;
    int checks = 0;

    adder_share_arbiter #(.FAIR(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .sum(sum), .busy(busy), .op_count(op_count)
    );

    adder_share_arbiter #(.FAIR(0), .CNT_W(4)) dut_fix (
        .clk(clk), .rst(rst),
        .req0(f_req0), .a0(f_a0), .b0(f_b0),
        .req1(f_req1), .a1(f_a1), .b1(f_b1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .ack0(f_ack0), .ack1(f_ack1),
        .sum(f_sum), .busy(f_busy), .op_count(f_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded wait for the next ack on either instance; sampled on falling edges
    task automatic wait_ack(input bit sel, output logic g0, output logic g1,
                            output logic [8:0] s, output bit to);
        to = 1'b1; g0 = 1'b0; g1 = 1'b0; s = 9'h000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!sel && (ack0 || ack1)) begin
                g0 = ack0; g1 = ack1; s = sum; to = 1'b0; break;
            end else if (sel && (f_ack0 || f_ack1)) begin
                g0 = f_ack0; g1 = f_ack1; s = f_sum; to = 1'b0; break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000", {gnt0, gnt1, ack0, ack1, busy});
        end
        checks++;
        if (sum !== 9'h000) begin
            errors++; $display("FAIL reset_sum got=%h exp=000", sum);
        end
        checks++;
        if (op_count !== 16'h0000 || f_op_count !== 4'h0) begin
            errors++; $display("FAIL reset_count got=%h/%h exp=0/0", op_count, f_op_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, busy, ack0} !== 4'b1010) begin
            errors++; $display("FAIL single_grant got=%b exp=1010", {gnt0, gnt1, busy, ack0});
        end
        @(negedge clk);
        checks++;
        if ({ack0, ack1, sum} !== {2'b10, 9'h046}) begin
            errors++; $display("FAIL single_ack got=%b%b sum=%h exp=10 sum=046", ack0, ack1, sum);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, busy, op_count} !== {2'b00, 16'd1}) begin
            errors++; $display("FAIL single_done got ack=%b busy=%b cnt=%0d exp 0 0 1", ack0, busy, op_count);
        end
    endtask

    task automatic test_carry();
        logic g0, g1; logic [8:0] s; bit to;
        req1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
        wait_ack(1'b0, g0, g1, s, to);
        checks++;
        if ({to, g0, g1, s} !== {3'b001, 9'h1FE}) begin
            errors++; $display("FAIL carry_ff got to=%b ack=%b%b sum=%h exp 0 01 1fe", to, g0, g1, s);
        end
        a1 = 8'h80; b1 = 8'h80;
        wait_ack(1'b0, g0, g1, s, to);
        checks++;
        if ({to, g0, g1, s} !== {3'b001, 9'h100}) begin
            errors++; $display("FAIL carry_80 got to=%b ack=%b%b sum=%h exp 0 01 100", to, g0, g1, s);
        end
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (op_count !== 16'd3) begin
            errors++; $display("FAIL carry_count got=%0d exp=3", op_count);
        end
    endtask

    task automatic test_fair();
        logic g0, g1; logic [8:0] s; bit to;
        logic [1:0] exp_ack [4];
        logic [8:0] exp_sum [4];
        exp_ack[0] = 2'b10; exp_ack[1] = 2'b01; exp_ack[2] = 2'b10; exp_ack[3] = 2'b01;
        exp_sum[0] = 9'h002; exp_sum[1] = 9'h004; exp_sum[2] = 9'h002; exp_sum[3] = 9'h004;
        rst = 1'b1;
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h01;
        req1 = 1'b1; a1 = 8'h02; b1 = 8'h02;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1'b0, g0, g1, s, to);
            checks++;
            if ({to, g0, g1, s} !== {1'b0, exp_ack[k], exp_sum[k]}) begin
                errors++; $display("FAIL fair_order_%0d got to=%b ack=%b%b sum=%h exp ack=%b sum=%h",
                                   k, to, g0, g1, s, exp_ack[k], exp_sum[k]);
            end
            checks++;
            if ((gnt0 & gnt1) !== 1'b0) begin
                errors++; $display("FAIL fair_gnt_excl_%0d got both grants high", k);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_isolation();
        logic g0, g1; logic [8:0] s; bit to;
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h01;
        @(negedge clk);
        a0 = 8'hAA;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL iso_grant got=%b%b exp=10", gnt0, gnt1);
        end
        wait_ack(1'b0, g0, g1, s, to);
        checks++;
        if ({to, g0, g1, s} !== {3'b010, 9'h002}) begin
            errors++; $display("FAIL iso_sum got to=%b ack=%b%b sum=%h exp 0 10 002", to, g0, g1, s);
        end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        logic g0, g1; logic [8:0] s; bit to;
        f_req0 = 1'b1; f_a0 = 8'h10; f_b0 = 8'h05;
        f_req1 = 1'b1; f_a1 = 8'h20; f_b1 = 8'h20;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1'b1, g0, g1, s, to);
            checks++;
            if ({to, g0, g1, s} !== {3'b010, 9'h015}) begin
                errors++; $display("FAIL fixed_prio_%0d got to=%b ack=%b%b sum=%h exp 0 10 015", k, to, g0, g1, s);
            end
        end
        f_req1 = 1'b0;
    endtask

    // Continues from test_fixed with f_req0 still held: ops 4..16 on the 4-bit counter
    task automatic test_wrap();
        logic g0, g1; logic [8:0] s; bit to;
        for (int k = 4; k <= 16; k++) begin
            wait_ack(1'b1, g0, g1, s, to);
            if (to) begin
                checks++; errors++;
                $display("FAIL wrap_timeout op=%0d", k);
                break;
            end
        end
        checks++;
        if (f_op_count !== 4'hF) begin
            errors++; $display("FAIL wrap_before got=%h exp=f", f_op_count);
        end
        f_req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (f_op_count !== 4'h0) begin
            errors++; $display("FAIL wrap_after got=%h exp=0", f_op_count);
        end
    endtask

    task automatic test_reset_mid();
        logic g0, g1; logic [8:0] s; bit to;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; a0 = 8'h03; b0 = 8'h04;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, ack0, ack1, busy, op_count} !== {5'b00000, 16'd0}) begin
            errors++; $display("FAIL rstmid_abort got ctl=%b cnt=%0d exp 00000 0",
                               {gnt0, gnt1, ack0, ack1, busy}, op_count);
        end
        @(negedge clk);
        checks++;
        if ({ack0, ack1, op_count} !== {2'b00, 16'd0}) begin
            errors++; $display("FAIL rstmid_noack got ack=%b%b cnt=%0d exp 00 0", ack0, ack1, op_count);
        end
        rst = 1'b0;
        wait_ack(1'b0, g0, g1, s, to);
        checks++;
        if ({to, g0, g1, s} !== {3'b010, 9'h007}) begin
            errors++; $display("FAIL rstmid_retry got to=%b ack=%b%b sum=%h exp 0 10 007", to, g0, g1, s);
        end
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (op_count !== 16'd1) begin
            errors++; $display("FAIL rstmid_count got=%0d exp=1", op_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
        req1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        f_req0 = 1'b0; f_a0 = 8'h00; f_b0 = 8'h00;
        f_req1 = 1'b0; f_a1 = 8'h00; f_b1 = 8'h00;
        test_reset();
        test_single();
        test_carry();
        test_fair();
        test_isolation();
        test_fixed();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
